// File: rtl/vc_iter_divider.sv
// vc_iter_divider -- multi-cycle radix-2 restoring divider.
//
// Produces quotient and remainder for signed or unsigned operands. Signedness
// is selected per request. Only one division is in flight at a time. A normal
// division spends exactly p_nbits cycles in CALC.
//
// Parameters:
//   p_nbits         operand/result width (>=2)
//   p_dbz_fastpath  1: divide-by-zero and signed overflow go straight to DONE
//
// Ports:
//   clk, reset            clock; async active-high reset
//   req_val/req_rdy       request handshake; rdy high only in IDLE
//   req_signed            1: two's-complement division, 0: unsigned
//   req_a, req_b          dividend, divisor
//   resp_val/resp_rdy     response handshake; val high only in DONE
//   resp_quot, resp_rem   registered quotient / remainder
//   resp_dbz              registered divide-by-zero flag
module vc_iter_divider #(
  parameter int p_nbits        = 32,
  parameter int p_dbz_fastpath = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic               req_signed,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_quot,
  output logic [p_nbits-1:0] resp_rem,
  output logic               resp_dbz
);

  localparam int CW = $clog2(p_nbits);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [p_nbits:0]   r;      // partial remainder, one guard bit for the sign
  logic [p_nbits-1:0] q;      // dividend shifts out, quotient shifts in
  logic [p_nbits-1:0] bmag;
  logic [p_nbits-1:0] a_q;    // original dividend, returned as rem on dbz
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r, dbz;

  assign req_rdy  = (state == IDLE);
  assign resp_val = (state == DONE);

  // Accept-side decode
  logic               a_neg, b_neg, b_zero, ovf_in;
  logic [p_nbits-1:0] amag_in, bmag_in;

  assign a_neg   = req_signed & req_a[p_nbits-1];
  assign b_neg   = req_signed & req_b[p_nbits-1];
  assign amag_in = a_neg ? -req_a : req_a;
  assign bmag_in = b_neg ? -req_b : req_b;
  assign b_zero  = (req_b == '0);
  assign ovf_in  = req_signed && (req_a == {1'b1, {(p_nbits-1){1'b0}}}) && (req_b == '1);

  // One restoring step
  logic [p_nbits:0]   r_sh, diff, r_nx;
  logic [p_nbits-1:0] q_sh, q_nx;

  assign r_sh = {r[p_nbits-1:0], q[p_nbits-1]};
  assign q_sh = {q[p_nbits-2:0], 1'b0};
  assign diff = r_sh - {1'b0, bmag};
  assign r_nx = diff[p_nbits] ? r_sh : diff;
  assign q_nx = diff[p_nbits] ? q_sh : (q_sh | p_nbits'(1));

  // Sign fixup on the final step. Signed overflow falls out naturally
  // (|MIN|/1 = MIN bit pattern, no negation), so only dbz needs an override.
  logic [p_nbits-1:0] quot_fx, rem_fx;

  assign quot_fx = dbz ? '1  : (neg_q ? -q_nx : q_nx);
  assign rem_fx  = dbz ? a_q : (neg_r ? -r_nx[p_nbits-1:0] : r_nx[p_nbits-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      bmag      <= '0;
      a_q       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dbz       <= 1'b0;
      resp_quot <= '0;
      resp_rem  <= '0;
      resp_dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_val) begin
          a_q   <= req_a;
          bmag  <= bmag_in;
          q     <= amag_in;
          r     <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dbz   <= b_zero;
          cnt   <= CW'(p_nbits - 1);
          if ((p_dbz_fastpath != 0) && (b_zero || ovf_in)) begin
            state     <= DONE;
            resp_quot <= b_zero ? '1 : req_a;
            resp_rem  <= b_zero ? req_a : '0;
            resp_dbz  <= b_zero;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            resp_quot <= quot_fx;
            resp_rem  <= rem_fx;
            resp_dbz  <= dbz;
          end
        end
        DONE: if (resp_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_iter_divider.sv
// Directed bench for vc_iter_divider (p_nbits=8). Two instances share the
// request/response stimulus: u_fp with the fast path, u_nf without it.
module tb_vc_iter_divider;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  logic req_val, req_signed, resp_rdy;
  logic [N-1:0] req_a, req_b;
  logic [1:0] req_rdy, resp_val, resp_dbz;
  logic [1:0][N-1:0] quot, rem;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vc_iter_divider #(.p_nbits(N), .p_dbz_fastpath(1)) u_fp (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy[0]),
    .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val[0]), .resp_rdy(resp_rdy), .resp_quot(quot[0]),
    .resp_rem(rem[0]), .resp_dbz(resp_dbz[0]));

  vc_iter_divider #(.p_nbits(N), .p_dbz_fastpath(0)) u_nf (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy[1]),
    .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val[1]), .resp_rdy(resp_rdy), .resp_quot(quot[1]),
    .resp_rem(rem[1]), .resp_dbz(resp_dbz[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, plus the dbz and overflow rules.
  task automatic model(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] eq, output logic [N-1:0] er, output logic ed);
    int sa, sb;
    ed = 1'b0;
    if (b == 0) begin
      eq = '1; er = a; ed = 1'b1;
    end else if (sgn && a == 8'h80 && b == 8'hFF) begin
      eq = 8'h80; er = 8'h00;
    end else if (sgn) begin
      sa = {{24{a[N-1]}}, a};
      sb = {{24{b[N-1]}}, b};
      eq = N'(sa / sb);
      er = N'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  // Issue one request to both instances and check both responses.
  // Expected latency -1 means "don't check" (used with random stalls).
  task automatic run(input string tag, input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                     input int lat_fp, input int lat_nf, input bit stall);
    logic [N-1:0] eq, er;
    logic ed;
    logic [1:0] seen;
    logic [1:0][N-1:0] gq, gr;
    logic [1:0] gd;
    int lat [2];
    int cyc;
    bit rdy_bad;
    model(sgn, a, b, eq, er, ed);
    seen = '0; gq = '0; gr = '0; gd = '0; lat[0] = 0; lat[1] = 0; cyc = 0; rdy_bad = 0;
    @(negedge clk);
    req_val = 1'b1; req_signed = sgn; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    // scramble inputs after accept; the DUT must ignore them
    req_val = 1'b0; req_signed = 1'($urandom); req_a = N'($urandom); req_b = N'($urandom);
    while (!(seen[0] && req_rdy[0] && seen[1] && req_rdy[1]) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!seen[i] && resp_val[i]) begin
          seen[i] = 1'b1; lat[i] = cyc; gq[i] = quot[i]; gr[i] = rem[i]; gd[i] = resp_dbz[i];
        end
        if (!seen[i] && req_rdy[i]) rdy_bad = 1;
      end
      resp_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    resp_rdy = 1'b1;
    chk({tag, " done"}, {30'd0, seen}, 32'd3);
    chk({tag, " rdy_low"}, 32'(rdy_bad), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s[%0d] quot", tag, i), 32'(gq[i]), 32'(eq));
      chk($sformatf("%s[%0d] rem", tag, i), 32'(gr[i]), 32'(er));
      chk($sformatf("%s[%0d] dbz", tag, i), 32'(gd[i]), 32'(ed));
    end
    if (lat_fp >= 0) chk({tag, " lat_fp"}, 32'(lat[0]), 32'(lat_fp));
    if (lat_nf >= 0) chk({tag, " lat_nf"}, 32'(lat[1]), 32'(lat_nf));
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      3: return 8'h80;
      4: return 8'h7F;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [N-1:0] hq, hr;
    bit bad;
    int cyc;
    reset = 1'b1; req_val = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0; resp_rdy = 1'b1;
    #1;
    chk("rst req_rdy", 32'(req_rdy), 32'd3);
    chk("rst resp_val", 32'(resp_val), 32'd0);
    chk("rst quot", 32'(quot), 32'd0);
    chk("rst rem", 32'(rem), 32'd0);
    chk("rst dbz", 32'(resp_dbz), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // 1-4: directed values and latencies
    run("t1 100/7", 0, 8'd100, 8'd7, 9, 9, 0);
    run("t2 -7/2", 1, 8'hF9, 8'h02, 9, 9, 0);
    run("t2 7/-2", 1, 8'h07, 8'hFE, 9, 9, 0);
    run("t2 F9/2u", 0, 8'hF9, 8'h02, 9, 9, 0);
    run("t3 dbz", 0, 8'h2A, 8'h00, 1, 9, 0);
    run("t3 dbz s", 1, 8'hD6, 8'h00, 1, 9, 0);
    run("t4 ovf", 1, 8'h80, 8'hFF, 1, 9, 0);
    run("t4 80/FFu", 0, 8'h80, 8'hFF, 9, 9, 0);

    // 5: back-pressure
    @(negedge clk);
    req_val = 1'b1; req_signed = 1'b0; req_a = 8'd100; req_b = 8'd7; resp_rdy = 1'b0;
    @(posedge clk); #1 req_val = 1'b0;
    cyc = 0;
    while (resp_val != 2'b11 && cyc < 30) begin @(negedge clk); cyc++; end
    chk("t5 resp_val", 32'(resp_val), 32'd3);
    hq = quot[1]; hr = rem[1];
    chk("t5 quot", 32'(hq), 32'd14);
    chk("t5 rem", 32'(hr), 32'd2);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_val != 2'b11 || req_rdy != 2'b00 || quot != {hq, hq} || rem != {hr, hr}) bad = 1;
    end
    chk("t5 held", 32'(bad), 32'd0);
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("t5 idle rdy", 32'(req_rdy), 32'd3);
    chk("t5 idle val", 32'(resp_val), 32'd0);
    run("t5 b2b a", 0, 8'd255, 8'd16, 9, 9, 0);
    run("t5 b2b b", 1, 8'h81, 8'h03, 9, 9, 0);

    // 6: reset mid-CALC
    @(negedge clk);
    req_val = 1'b1; req_signed = 1'b0; req_a = 8'd50; req_b = 8'd3;
    @(posedge clk); #1 req_val = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6 rdy", 32'(req_rdy), 32'd3);
    chk("t6 val", 32'(resp_val), 32'd0);
    chk("t6 quot clr", 32'(quot), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (resp_val != 2'b00) bad = 1;
    end
    chk("t6 no stale", 32'(bad), 32'd0);
    run("t6 200/9", 0, 8'd200, 8'd9, 9, 9, 0);

    // random operands with corner values and response stalls
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run($sformatf("rnd%0d", k), 1'($urandom), pick(), pick(), -1, -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
